// File: rtl/serial_add_scheduler.sv
// Round-robin arbiter that time-shares one bit-serial adder among N requesters.
// One operation in flight at a time; a done-timeout watchdog answers with rsp_err_o.
module serial_add_scheduler #(
    parameter int N       = 4,
    parameter int W       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [N-1:0]   req_i,
    input  logic [N*W-1:0] req_a_i,
    input  logic [N*W-1:0] req_b_i,
    output logic [N-1:0]   gnt_o,
    output logic [N-1:0]   rsp_valid_o,
    output logic [W-1:0]   rsp_sum_o,
    output logic           rsp_err_o,
    output logic           busy_o,
    output logic [7:0]     ops_cnt_o,
    output logic           add_load_o,
    output logic           add_start_o,
    output logic [W-1:0]   add_a_o,
    output logic [W-1:0]   add_b_o,
    input  logic [W-1:0]   add_sum_i,
    input  logic           add_done_i
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [N-1:0]  ONE_N     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        state_q;
    logic [PW-1:0] ptr_q;
    logic [TW-1:0] tcnt_q;
    logic [N-1:0]  gnt_q;
    logic [N-1:0]  rsp_valid_q;
    logic [W-1:0]  rsp_sum_q;
    logic          rsp_err_q;
    logic          busy_q;
    logic [7:0]    ops_cnt_q;
    logic          add_load_q;
    logic          add_start_q;
    logic [W-1:0]  add_a_q;
    logic [W-1:0]  add_b_q;

    logic          pick_found_d;
    logic [PW-1:0] pick_idx_d;
    logic [W-1:0]  pick_a_d;
    logic [W-1:0]  pick_b_d;

    // Round-robin pick: first pending request strictly after the last grant, with wrap.
    always_comb begin
        logic [PW-1:0] cand;
        cand         = '0;
        pick_found_d = 1'b0;
        pick_idx_d   = ptr_q;
        for (int k = 1; k <= N; k++) begin
            cand = PW'((int'(ptr_q) + k) % N);
            if (!pick_found_d && req_i[cand]) begin
                pick_found_d = 1'b1;
                pick_idx_d   = cand;
            end else begin
                pick_found_d = pick_found_d;
            end
        end
        pick_a_d = req_a_i[pick_idx_d*W +: W];
        pick_b_d = req_b_i[pick_idx_d*W +: W];
    end

    // Controller FSM; every output is a register written only here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ptr_q       <= PW'(N - 1);
            tcnt_q      <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            ops_cnt_q   <= 8'd0;
            add_load_q  <= 1'b0;
            add_start_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_found_d) begin
                        gnt_q       <= ONE_N << pick_idx_d;
                        add_a_q     <= pick_a_d;
                        add_b_q     <= pick_b_d;
                        add_load_q  <= 1'b1;
                        add_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        ptr_q       <= pick_idx_d;
                        state_q     <= S_ISSUE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    gnt_q       <= '0;
                    add_load_q  <= 1'b0;
                    add_start_q <= 1'b0;
                    tcnt_q      <= '0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    // A done in the final watchdog cycle still counts as success.
                    if (add_done_i) begin
                        rsp_valid_q <= ONE_N << ptr_q;
                        rsp_sum_q   <= add_sum_i;
                        rsp_err_q   <= 1'b0;
                        ops_cnt_q   <= ops_cnt_q + 8'd1;
                        state_q     <= S_RESP;
                    end else if (tcnt_q == TCNT_LAST) begin
                        rsp_valid_q <= ONE_N << ptr_q;
                        rsp_sum_q   <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                S_RESP: begin
                    rsp_valid_q <= '0;
                    rsp_sum_q   <= '0;
                    rsp_err_q   <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    gnt_q       <= '0;
                    rsp_valid_q <= '0;
                    rsp_sum_q   <= '0;
                    rsp_err_q   <= 1'b0;
                    busy_q      <= 1'b0;
                    add_load_q  <= 1'b0;
                    add_start_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_sum_o   = rsp_sum_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;
    assign ops_cnt_o   = ops_cnt_q;
    assign add_load_o  = add_load_q;
    assign add_start_o = add_start_q;
    assign add_a_o     = add_a_q;
    assign add_b_o     = add_b_q;

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Self-checking bench for serial_add_scheduler with a behavioural serial-adder model
// and a response scoreboard.
module tb_serial_add_scheduler;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   gnt_o;
    logic [N-1:0]   rsp_valid_o;
    logic [W-1:0]   rsp_sum_o;
    logic           rsp_err_o;
    logic           busy_o;
    logic [7:0]     ops_cnt_o;
    logic           add_load_o;
    logic           add_start_o;
    logic [W-1:0]   add_a_o;
    logic [W-1:0]   add_b_o;
    logic [W-1:0]   add_sum = 4'd0;
    logic           add_done = 1'b0;

    serial_add_scheduler #(.N(N), .W(W), .TIMEOUT(TO)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .gnt_o       (gnt_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_sum_o   (rsp_sum_o),
        .rsp_err_o   (rsp_err_o),
        .busy_o      (busy_o),
        .ops_cnt_o   (ops_cnt_o),
        .add_load_o  (add_load_o),
        .add_start_o (add_start_o),
        .add_a_o     (add_a_o),
        .add_b_o     (add_b_o),
        .add_sum_i   (add_sum),
        .add_done_i  (add_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [3:0] sum;
        logic       err;
    } exp_t;

    typedef struct {
        int         idx;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sum;
    } vec_t;

    exp_t       sb_q[$];
    vec_t       vecs[6];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_ops = 8'd0;

    // Adder model: done appears lat cycles after the start strobe is sampled.
    int         lat   = 5;
    bit         stall = 1'b0;
    int         acnt  = 0;
    logic [3:0] al    = 4'd0;
    logic [3:0] bl    = 4'd0;

    always @(posedge clk) begin
        add_done <= 1'b0;
        add_sum  <= 4'($urandom);
        if (add_start_o) begin
            acnt <= lat;
            al   <= add_a_o;
            bl   <= add_b_o;
        end else if (acnt > 0) begin
            acnt <= acnt - 1;
            if (acnt == 1 && !stall) begin
                add_done <= 1'b1;
                add_sum  <= al + bl;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard consumer: every rsp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            exp_ops = 8'd0;
        end else if (rsp_valid_o != '0) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
            end else begin
                exp_t e;
                logic [N-1:0] ev;
                e  = sb_q.pop_front();
                ev = 4'b0001 << e.idx;
                check("rsp_valid", 32'(rsp_valid_o), 32'(ev));
                check("rsp_sum", 32'(rsp_sum_o), 32'(e.sum));
                check("rsp_err", 32'(rsp_err_o), 32'(e.err));
                if (!e.err) exp_ops = exp_ops + 8'd1;
                check("ops_cnt", 32'(ops_cnt_o), 32'(exp_ops));
            end
        end
    end

    task automatic set_op(input int idx, input logic [3:0] a, input logic [3:0] b);
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req[idx]          = 1'b1;
    endtask

    task automatic push(input int idx, input logic [3:0] sum, input logic err);
        exp_t e;
        e.idx = idx;
        e.sum = sum;
        e.err = err;
        sb_q.push_back(e);
    endtask

    task automatic wait_rsp(input int idx, output int cyc);
        cyc = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid_o[idx]) begin
                cyc = c;
                break;
            end
        end
        if (cyc < 0) check("rsp_wait_budget", 32'd0, 32'd1);
    endtask

    task automatic drop(input int idx);
        @(posedge clk);
        #1;
        req[idx] = 1'b0;
    endtask

    task automatic run_op(input int idx, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] sum, input logic err, output int cyc);
        @(posedge clk);
        #1;
        set_op(idx, a, b);
        push(idx, sum, err);
        wait_rsp(idx, cyc);
        drop(idx);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [3:0] ra;
        logic [3:0] rb;

        rst   = 1'b1;
        req   = '0;
        req_a = '0;
        req_b = '0;
        vecs[0] = '{0, 4'd3,  4'd5,  4'd8};
        vecs[1] = '{1, 4'd9,  4'd9,  4'd2};
        vecs[2] = '{2, 4'd15, 4'd1,  4'd0};
        vecs[3] = '{3, 4'd0,  4'd0,  4'd0};
        vecs[4] = '{1, 4'd7,  4'd8,  4'd15};
        vecs[5] = '{2, 4'd15, 4'd15, 4'd14};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ops", 32'(ops_cnt_o), 32'd0);
        check("rst_start", 32'({add_load_o, add_start_o}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single op with cycle-exact handshake timing
        @(posedge clk);
        #1;
        set_op(0, 4'd3, 4'd5);
        push(0, 4'd8, 1'b0);
        cyc = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) begin
                check("t1_gnt", 32'(gnt_o), 32'd1);
                check("t1_load_start", 32'({add_load_o, add_start_o}), 32'd3);
                check("t1_add_a", 32'(add_a_o), 32'd3);
                check("t1_add_b", 32'(add_b_o), 32'd5);
                check("t1_busy", 32'(busy_o), 32'd1);
            end
            if (c == 2) begin
                check("t1_gnt_drop", 32'(gnt_o), 32'd0);
                check("t1_start_drop", 32'({add_load_o, add_start_o}), 32'd0);
            end
            if (c == 6) check("t1_add_a_hold", 32'(add_a_o), 32'd3);
            if (rsp_valid_o != '0) begin
                cyc = c;
                break;
            end
        end
        check("t1_rsp_cycle", 32'(cyc), 32'd8);
        drop(0);
        @(negedge clk);
        check("t1_rsp_pulse", 32'(rsp_valid_o), 32'd0);
        check("t1_busy_idle", 32'(busy_o), 32'd0);

        // Table of single operations
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].sum, 1'b0, cyc);
            check("vec_latency", 32'(cyc), 32'd8);
        end

        // Round robin from reset pointer, then wrap, then a held request
        do_reset();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            set_op(k, 4'(k + 1), 4'(2 * k));
            push(k, 4'(3 * k + 1), 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            wait_rsp(k, cyc);
            drop(k);
        end
        @(posedge clk);
        #1;
        set_op(3, 4'd6, 4'd6);
        set_op(0, 4'd2, 4'd2);
        push(0, 4'd4, 1'b0);
        push(3, 4'd12, 1'b0);
        wait_rsp(0, cyc);
        drop(0);
        wait_rsp(3, cyc);
        drop(3);
        @(posedge clk);
        #1;
        set_op(1, 4'd1, 4'd1);
        set_op(2, 4'd5, 4'd5);
        push(1, 4'd2, 1'b0);
        push(2, 4'd10, 1'b0);
        push(1, 4'd2, 1'b0);
        wait_rsp(1, cyc);
        wait_rsp(2, cyc);
        drop(2);
        wait_rsp(1, cyc);
        drop(1);

        // Watchdog, then done-versus-timeout boundaries
        stall = 1'b1;
        run_op(1, 4'd4, 4'd4, 4'd0, 1'b1, cyc);
        check("timeout_cycle", 32'(cyc), 32'd18);
        stall = 1'b0;
        run_op(1, 4'd4, 4'd4, 4'd8, 1'b0, cyc);
        check("after_timeout", 32'(cyc), 32'd8);
        lat = 15;
        run_op(3, 4'd10, 4'd3, 4'd13, 1'b0, cyc);
        check("done_last_cycle", 32'(cyc), 32'd18);
        lat = 16;
        run_op(3, 4'd10, 4'd3, 4'd0, 1'b1, cyc);
        check("done_too_late", 32'(cyc), 32'd18);
        lat = 5;

        // Reset while WAIT; the stale adder done lands in the next ISSUE
        @(posedge clk);
        #1;
        set_op(0, 4'd1, 4'd2);
        push(0, 4'd3, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_rsp", 32'(rsp_valid_o), 32'd0);
        check("mid_rst_ops", 32'(ops_cnt_o), 32'd0);
        check("mid_rst_add", 32'({add_load_o, add_start_o, add_a_o, add_b_o}), 32'd0);
        run_op(2, 4'd6, 4'd7, 4'd13, 1'b0, cyc);
        check("post_rst_op", 32'(cyc), 32'd8);

        // ops_cnt wrap after 256 successful operations
        do_reset();
        for (int i = 0; i < 255; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            run_op(i % N, ra, rb, ra + rb, 1'b0, cyc);
        end
        @(negedge clk);
        check("ops_255", 32'(ops_cnt_o), 32'd255);
        run_op(1, 4'd2, 4'd3, 4'd5, 1'b0, cyc);
        @(negedge clk);
        check("ops_wrap", 32'(ops_cnt_o), 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
